fif_psh_arb: RTL and testbench
==============================

// Module: fif_psh_arb
// PURPOSE
//  Round-robin push arbiter that shares one flop-out FIFO (head-entry read, psh/pop/cnt
//  interface) between NUM_REQ producers. Tracks FIFO occupancy locally with a credit
//  counter. Issues a registered psh/data beat one cycle after grant.
//  Sits directly in front of the FIFO's data_in/psh port; the consumer drives pop.
// PARAMETERS
//  NUM_REQ     4                    number of requesters (>=2)
//  DATA_WIDTH  5                    payload width, matches FIFO data_in
//  DEPTH       8                    FIFO entry count, matches FIFO DEPTH
//  CNT_WIDTH   $clog2(DEPTH)+1      width of occupancy/cnt, matches FIFO cnt
// PORTS
//  clk        in   1                     clock
//  rst_n      in   1                     async active-low reset
//  req_vld    in   NUM_REQ               per-requester beat valid
//  req_dat    in   NUM_REQ x DATA_WIDTH  per-requester payload
//  req_rdy    out  NUM_REQ               per-requester accept; beat transfers on vld&rdy
//  fif_pop    in   1                     FIFO pop (same signal the consumer drives)
//  fif_cnt    in   CNT_WIDTH             FIFO cnt output, used only for consistency check
//  fif_psh    out  1                     registered push to FIFO
//  fif_dat    out  DATA_WIDTH            registered data to FIFO data_in
//  gnt_id     out  $clog2(NUM_REQ)       index of requester whose beat is on fif_dat
//  occ        out  CNT_WIDTH             local occupancy (FIFO entries + in-flight beat)
//  err        out  1                     sticky: local occupancy disagrees with FIFO cnt
// BEHAVIOUR
//  - Reset (async, rst_n=0): fif_psh=0, fif_dat=0, gnt_id=0, occ=0, err=0, rr_ptr=0, lock=0.
//    Any in-flight beat is dropped. The FIFO is reset by the same rst_n.
//  - Credit: can_gnt = (occ < DEPTH) | fif_pop. A pop in the grant cycle frees the slot the
//    beat lands in next cycle. The FIFO allows psh&pop at full.
//  - Arbitration: combinational, rotating priority starting at rr_ptr, over req_vld.
//    Winner w gets req_rdy[w]=can_gnt; all other req_rdy=0. req_rdy depends on req_vld
//    combinationally. Requesters must not make vld depend on rdy.
//  - On a transfer (any vld&rdy): next cycle fif_psh=1, fif_dat=req_dat[w], gnt_id=w.
//    rr_ptr <= (w==NUM_REQ-1) ? 0 : w+1.
//  - With no transfer: fif_psh=0 next cycle; fif_dat and gnt_id hold; rr_ptr holds.
//  - Latency: exactly 1 cycle from vld&rdy to fif_psh. Throughput: 1 beat/cycle while credit lasts.
//  - occ <= occ + xfer - fif_pop. Width is CNT_WIDTH, range 0..DEPTH.
//    A pop at occ==0 is a consumer error: occ saturates at 0 and err is set.
//  - Check: every cycle out of reset, if occ != fif_cnt + fif_psh, then err <= 1.
//    err clears only on reset.
//  - Boundaries:
//    full (occ==DEPTH, no pop): all rdy=0, rr_ptr holds.
//    full with pop: one grant allowed.
//    empty: FIFO sees the pushed beat on data_out the cycle after fif_psh.
//    simultaneous xfer+pop: occ unchanged.
//    single requester: it is granted every cycle, with no fairness penalty.
//  - Assertions: $onehot0(req_rdy); never (fif_psh & !fif_pop & fif_cnt==DEPTH);
//    never (fif_pop & occ==0).
// CONFIGURATION
//  ARB_HOLD_EN defined:
//   - Adds input req_lst [NUM_REQ] (last beat of a packet).
//   - Adds a 2-state FSM:
//     ARB  -> LOCK on a transfer with req_lst[w]=0; lock_id <= w.
//     LOCK -> ARB on a transfer from lock_id with req_lst=1.
//   - In LOCK only lock_id can get rdy. If lock_id's vld is low, no grant (bubble).
//   - rr_ptr advances only on the ARB-returning (last) beat.
//   - Reset mid-packet returns the FSM to ARB.
//  ARB_HOLD_EN undefined:
//   - No req_lst port and no FSM. Every beat is arbitrated independently.
// TESTING
//  1 All 4 req_vld=1, no pop -> grants in order 0,1,2,3,0,1,2,3.
//    Then rdy=0 with occ=8; fif_cnt reaches 8; err=0.
//  2 occ=8, fif_pop=1 with req_vld[2]=1 -> req_rdy[2]=1 same cycle.
//    Next cycle fif_psh=1, gnt_id=2; occ stays 8.
//  3 Only req 1 valid for 5 cycles, pop every cycle after the first ->
//    5 consecutive beats, 1 cycle latency each, occ holds at 1.
//  4 Assert rst_n=0 asynchronously while fif_psh=1 with occ=5 ->
//    fif_psh, occ and err go to 0 immediately, without waiting for a clk edge.
//  5 Force fif_cnt off by one for one cycle -> err=1 next cycle and stays 1 until reset.
//  6 (ARB_HOLD_EN) req 0 sends a 3-beat packet (lst on the 3rd) while req 1 is valid ->
//    req 1 is granted only after beat 3; a vld gap mid-packet produces a bubble, not a grant to req 1.

Source files
------------

// File: rtl/fif_psh_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fif_psh_arb : round-robin push arbiter with local credit/occupancy check  |
// |   in front of a shared flop-out FIFO. Optional packet hold: ARB_HOLD_EN.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fif_psh_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_vld,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_dat,
`ifdef ARB_HOLD_EN
  input  logic [NUM_REQ-1:0]                   req_lst,
`endif
  output logic [NUM_REQ-1:0]                   req_rdy,
  input  logic                                 fif_pop,
  input  logic [CNT_WIDTH-1:0]                 fif_cnt,
  output logic                                 fif_psh,
  output logic [DATA_WIDTH-1:0]                fif_dat,
  output logic [$clog2(NUM_REQ)-1:0]           gnt_id,
  output logic [CNT_WIDTH-1:0]                 occ,
  output logic                                 err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);
  localparam logic [IW-1:0]        C_LAST  = IW'(NUM_REQ - 1);

  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        win;
  logic [IW-1:0]        idx;
  logic                 found;
  logic                 can_gnt;
  logic                 xfer;
  logic                 adv;
  logic [CNT_WIDTH-1:0] occ_nxt;
  logic                 mismatch;

`ifdef ARB_HOLD_EN
  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} arb_st_t;
  arb_st_t       state, state_nxt;
  logic [IW-1:0] lock_id;
`endif

  // Walk offsets from the farthest back to rr_ptr so the nearest valid one wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef ARB_HOLD_EN
    if (state == ST_LOCK) begin
      found = req_vld[lock_id];
      win   = lock_id;
    end
`endif
  end

  // A pop this cycle frees the slot the new beat occupies next cycle.
  assign can_gnt = (occ < C_DEPTH) | fif_pop;
  assign xfer    = found & can_gnt;

  always_comb begin
    req_rdy = '0;
    if (xfer) req_rdy[win] = 1'b1;
  end

`ifdef ARB_HOLD_EN
  // The pointer only moves when a packet completes.
  assign adv = xfer & req_lst[win];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:  if (xfer && !req_lst[win]) state_nxt = ST_LOCK;
      ST_LOCK: if (xfer &&  req_lst[win]) state_nxt = ST_ARB;
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ARB;
      lock_id <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ARB && xfer && !req_lst[win]) lock_id <= win;
    end
  end
`else
  assign adv = xfer;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fif_psh <= 1'b0;
      fif_dat <= '0;
      gnt_id  <= '0;
      rr_ptr  <= '0;
    end else begin
      fif_psh <= xfer;
      if (xfer) begin
        fif_dat <= req_dat[win];
        gnt_id  <= win;
      end
      if (adv) rr_ptr <= (win == C_LAST) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    if (fif_pop && occ == '0) occ_nxt = '0;
    else                      occ_nxt = occ + CNT_WIDTH'(xfer) - CNT_WIDTH'(fif_pop);
  end

  // occ counts the beat still on fif_psh, which the FIFO has not yet counted.
  assign mismatch = {1'b0, occ} != ({1'b0, fif_cnt} + {{CNT_WIDTH{1'b0}}, fif_psh});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
      err <= 1'b0;
    end else begin
      occ <= occ_nxt;
      if (mismatch || (fif_pop && occ == '0)) err <= 1'b1;
    end
  end

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_rdy));
  a_no_ovf:     assert property (@(posedge clk) disable iff (!rst_n)
                                 !(fif_psh && !fif_pop && fif_cnt == C_DEPTH));
  a_no_under:   assert property (@(posedge clk) disable iff (!rst_n) !(fif_pop && occ == '0));

endmodule
`default_nettype wire

// File: tb/tb_fif_psh_arb.sv
`default_nettype none
// tb_fif_psh_arb : directed bench with a spec-level model of arbitration, credit and FIFO count.
// Covers ARB_HOLD_EN packet hold when that macro is defined.
module tb_fif_psh_arb;
  localparam int NUM_REQ = 4;
  localparam int DW      = 5;
  localparam int DEPTH   = 8;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req_vld = '0;
  logic [NUM_REQ-1:0][DW-1:0] req_dat = '0;
  logic [NUM_REQ-1:0]         req_lst = '0;
  logic [NUM_REQ-1:0]         req_rdy;
  logic                       fif_pop = 1'b0;
  logic [CW-1:0]              fif_cnt;
  logic                       fif_psh;
  logic [DW-1:0]              fif_dat;
  logic [1:0]                 gnt_id;
  logic [CW-1:0]              occ;
  logic                       err;

  int total = 0;
  int bad   = 0;
  int seq   = 0;

  // Model state: what the outputs must be, plus the FIFO's own entry count.
  int          m_occ = 0, m_gid = 0, m_ptr = 0, fq_cnt = 0, cnt_bias = 0;
  logic        m_psh = 1'b0, m_err = 1'b0;
  logic [DW-1:0] m_dat = '0;
  logic        m_lock = 1'b0;
  int          m_lid = 0;

  assign fif_cnt = CW'(fq_cnt + cnt_bias);

  fif_psh_arb #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_dat(req_dat),
`ifdef ARB_HOLD_EN
    .req_lst(req_lst),
`endif
    .req_rdy(req_rdy), .fif_pop(fif_pop), .fif_cnt(fif_cnt), .fif_psh(fif_psh),
    .fif_dat(fif_dat), .gnt_id(gnt_id), .occ(occ), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int pick();
`ifdef ARB_HOLD_EN
    if (m_lock) return req_vld[m_lid] ? m_lid : -1;
`endif
    for (int k = 0; k < NUM_REQ; k++)
      if (req_vld[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic model_xfer();
    return (pick() >= 0) && ((m_occ < DEPTH) || fif_pop);
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_rdy();
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (model_xfer()) r[pick()] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_psh <= 1'b0; m_dat <= '0; m_gid <= 0; m_occ <= 0; m_err <= 1'b0;
      m_ptr <= 0; fq_cnt <= 0; m_lock <= 1'b0; m_lid <= 0;
    end else begin
      m_psh <= model_xfer();
      if (model_xfer()) begin
        m_dat <= req_dat[pick()];
        m_gid <= pick();
`ifdef ARB_HOLD_EN
        if (req_lst[pick()]) begin
          m_ptr  <= (pick() + 1) % NUM_REQ;
          m_lock <= 1'b0;
        end else if (!m_lock) begin
          m_lock <= 1'b1;
          m_lid  <= pick();
        end
`else
        m_ptr <= (pick() + 1) % NUM_REQ;
`endif
      end
      m_occ  <= (fif_pop && m_occ == 0) ? 0 : m_occ + int'(model_xfer()) - int'(fif_pop);
      if ((fif_pop && m_occ == 0) || (m_occ != fq_cnt + cnt_bias + int'(m_psh))) m_err <= 1'b1;
      fq_cnt <= fq_cnt + int'(fif_psh) - int'(fif_pop);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rdy", 32'(req_rdy), 32'(exp_rdy()));
      chk("psh", 32'(fif_psh), 32'(m_psh));
      chk("dat", 32'(fif_dat), 32'(m_dat));
      chk("gnt", 32'(gnt_id), 32'(m_gid));
      chk("occ", 32'(occ), 32'(m_occ));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic drive(input logic [NUM_REQ-1:0] v, input logic p, input logic [NUM_REQ-1:0] l);
    @(posedge clk);
    #1;
    req_vld = v;
    req_lst = l;
    fif_pop = p && (m_occ != 0);
    for (int i = 0; i < NUM_REQ; i++) req_dat[i] = DW'(i * 9 + seq);
    seq++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g[$];
    int exp_order[8];
    int beats;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_psh", 32'(fif_psh), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_gnt", 32'(gnt_id), 0);
    chk("rst_dat", 32'(fif_dat), 0);
    rst_n = 1'b1;

    // 1: all valid, no pop -> rotating grants until credit runs out
    for (int c = 0; c < 10; c++) begin
      drive(4'hF, 1'b0, 4'hF);
      @(negedge clk);
      if (fif_psh) g.push_back(int'(gnt_id));
    end
    chk("t1_beats", 32'(g.size()), 8);
    for (int i = 0; i < 8 && i < g.size(); i++) chk("t1_order", 32'(g[i]), 32'(exp_order[i]));
    chk("t1_rdy_full", 32'(req_rdy), 0);
    chk("t1_occ", 32'(occ), 8);
    chk("t1_cnt", 32'(fif_cnt), 8);
    chk("t1_err", 32'(err), 0);

    // 2: full with pop -> single grant, occupancy unchanged
    drive(4'b0100, 1'b1, 4'hF);
    @(negedge clk);
    chk("t2_rdy", 32'(req_rdy), 32'h4);
    drive(4'b0000, 1'b0, 4'hF);
    @(negedge clk);
    chk("t2_psh", 32'(fif_psh), 1);
    chk("t2_gnt", 32'(gnt_id), 2);
    chk("t2_occ", 32'(occ), 8);
    repeat (8) drive(4'b0000, 1'b1, 4'hF);
    drive(4'b0000, 1'b0, 4'hF);
    @(negedge clk);
    chk("t2_drain", 32'(occ), 0);

    // 3: single requester streams with pops -> one beat per cycle, occ steady at 1
    beats = 0;
    drive(4'b0010, 1'b0, 4'hF);
    for (int c = 0; c < 5; c++) begin
      drive((c < 4) ? 4'b0010 : 4'b0000, 1'b1, 4'hF);
      @(negedge clk);
      if (fif_psh && gnt_id == 2'd1) beats++;
      chk("t3_occ", 32'(occ), 1);
    end
    chk("t3_beats", 32'(beats), 5);
    drive(4'b0000, 1'b0, 4'hF);
    @(negedge clk);
    chk("t3_empty", 32'(occ), 0);

    // 5: fif_cnt off by one for one cycle -> sticky err
    drive(4'b0000, 1'b0, 4'hF);
    cnt_bias = 1;
    drive(4'b0000, 1'b0, 4'hF);
    cnt_bias = 0;
    @(negedge clk);
    chk("t5_err", 32'(err), 1);
    repeat (3) drive(4'b0000, 1'b0, 4'hF);
    @(negedge clk);
    chk("t5_sticky", 32'(err), 1);

    // 4: asynchronous reset mid-cycle with a beat in flight
    repeat (5) drive(4'hF, 1'b0, 4'hF);
    drive(4'b0000, 1'b0, 4'hF);
    @(negedge clk);
    chk("t4_pre_occ", 32'(occ), 5);
    chk("t4_pre_psh", 32'(fif_psh), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_psh", 32'(fif_psh), 0);
    chk("t4_occ", 32'(occ), 0);
    chk("t4_err", 32'(err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Pointer restarts at 0 after reset
    drive(4'b1001, 1'b0, 4'hF);
    @(negedge clk);
    chk("rst_ptr", 32'(req_rdy), 32'h1);
    drive(4'b1000, 1'b0, 4'hF);
    @(negedge clk);
    chk("rst_ptr2", 32'(req_rdy), 32'h8);

`ifdef ARB_HOLD_EN
    // 6: req 0 holds the arbiter for a 3-beat packet; a vld gap is a bubble
    drive(4'b0011, 1'b0, 4'b0000);
    @(negedge clk);
    chk("t6_b1", 32'(req_rdy), 32'h1);
    drive(4'b0011, 1'b0, 4'b0000);
    @(negedge clk);
    chk("t6_b2", 32'(req_rdy), 32'h1);
    drive(4'b0010, 1'b0, 4'b0000);
    @(negedge clk);
    chk("t6_bubble", 32'(req_rdy), 32'h0);
    drive(4'b0011, 1'b0, 4'b0001);
    @(negedge clk);
    chk("t6_b3", 32'(req_rdy), 32'h1);
    drive(4'b0010, 1'b0, 4'b0010);
    @(negedge clk);
    chk("t6_next", 32'(req_rdy), 32'h2);
`endif

    drive(4'b0000, 1'b0, 4'hF);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
